noc_traffic_harness: RTL and testbench

- Synthesizable traffic source and multi-sink monitor for exercising the NoC `system` top on FPGA or in simulation.
- Replays a preloaded packet array into the single injection port (stab), with optional inter-packet gaps.
- Absorbs N_SINK ejection ports (flee), with optional periodic backpressure, and counts traffic.
- Flags deadlock using a windowed progress watchdog and detects end of traffic with a drain-idle timeout.

---
 rtl/noc_traffic_harness.sv | 242 ++++++++++++++++++++++++
 tb/tb_noc_traffic_harness.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_harness.sv
// noc_traffic_harness
// Traffic source and multi-sink monitor for exercising a NoC on FPGA or in
// simulation. A preloaded packet memory is replayed into a single injection
// port with optional inter-packet gaps. N_SINK ejection ports are absorbed
// with optional periodic backpressure and per-sink counting. A windowed
// progress watchdog flags deadlock; a drain-idle timeout marks end of traffic.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data           packet memory write (IDLE/DONE/DEADLOCK only)
//   start                           run start pulse (IDLE/DONE only)
//   pkt_num, loop_en, gap, bp_en    run configuration, sampled on start
//   data_o_stab/valid_o_stab/ready_i_stab   injection channel
//   data_i_flee/valid_i_flee/ready_o_flee   ejection channels (k at [k*DW +: DW])
//   sent_cnt, rcv_cnt               saturating transfer counters
//   busy, done, deadlock            status
module noc_traffic_harness #(
  parameter int DW        = 32,
  parameter int DEPTH     = 10000,
  parameter int N_SINK    = 2,
  parameter int WIN       = 10000,
  parameter int DRAIN_CYC = 1024,
  parameter int BP_PERIOD = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DW-1:0]        ld_data,
  input  logic                 start,
  input  logic [AW:0]          pkt_num,
  input  logic                 loop_en,
  input  logic [7:0]           gap,
  input  logic [N_SINK-1:0]    bp_en,
  output logic [DW-1:0]        data_o_stab,
  output logic                 valid_o_stab,
  input  logic                 ready_i_stab,
  input  logic [N_SINK*DW-1:0] data_i_flee,
  input  logic [N_SINK-1:0]    valid_i_flee,
  output logic [N_SINK-1:0]    ready_o_flee,
  output logic [31:0]          sent_cnt,
  output logic [N_SINK*32-1:0] rcv_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 deadlock
);

  localparam int WW  = $clog2(WIN + 1);
  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam int BPW = $clog2(BP_PERIOD + 1);
  localparam logic [WW-1:0]  WIN_LAST = WW'(WIN - 1);
  localparam logic [DCW-1:0] DC_LAST  = DCW'(DRAIN_CYC - 1);
  localparam logic [BPW-1:0] BP_LAST  = BPW'(BP_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_DRAIN, S_DONE, S_DEAD
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [7:0]               gap_cnt_q, gap_cnt_d;
  logic [DCW-1:0]           idle_q, idle_d;
  logic [WW-1:0]            win_q, win_d;
  logic [31:0]              snap_q, snap_d;
  logic [BPW-1:0]           bp_q, bp_d;
  logic [31:0]              sent_q, sent_d;
  logic [N_SINK-1:0][31:0]  rcv_q, rcv_d;

  // Run configuration captured on an accepted start
  logic [AW:0]              pkt_num_q;
  logic                     loop_q;
  logic [7:0]               gap_q;
  logic [N_SINK-1:0]        bp_en_q;

  logic [DW-1:0]            mem [DEPTH];

  logic                     start_ok, ld_ok, active, inj_xfer, last_pkt, trip;
  logic [N_SINK-1:0]        snk_xfer;
  logic [31:0]              progress;
  logic                     unused_flee;

  // Ejected payloads are only counted, never inspected
  assign unused_flee = ^data_i_flee;

  assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign ld_ok    = (state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_DEAD);
  assign active   = (state_q == S_SEND) | (state_q == S_GAP) | (state_q == S_DRAIN);

  assign valid_o_stab = (state_q == S_SEND);
  assign data_o_stab  = mem[addr_q];
  assign inj_xfer     = valid_o_stab & ready_i_stab;
  assign last_pkt     = ({1'b0, addr_q} == (pkt_num_q - 1'b1));

  assign busy     = active;
  assign done     = (state_q == S_DONE);
  // DEADLOCK is only left through reset, so the state itself is sticky
  assign deadlock = (state_q == S_DEAD);

  assign sent_cnt = sent_q;
  assign rcv_cnt  = rcv_q;

  always_comb begin
    for (int k = 0; k < N_SINK; k++) begin
      ready_o_flee[k] = ~((state_q == S_IDLE) | (state_q == S_DEAD)) &
                        ~(bp_en_q[k] & (bp_q == BP_LAST));
    end
  end

  assign snk_xfer = valid_i_flee & ready_o_flee;

  always_comb begin
    progress = sent_q;
    for (int k = 0; k < N_SINK; k++) begin
      progress = progress + rcv_q[k];
    end
  end

  // Packet memory: no reset, writes locked out while traffic is running
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    gap_cnt_d = gap_cnt_q;
    idle_d    = idle_q;
    win_d     = win_q;
    snap_d    = snap_q;
    bp_d      = (bp_q == BP_LAST) ? '0 : bp_q + 1'b1;
    sent_d    = sent_q;
    rcv_d     = rcv_q;
    trip      = 1'b0;

    if (inj_xfer && (sent_q != 32'hFFFF_FFFF)) begin
      sent_d = sent_q + 32'd1;
    end
    for (int k = 0; k < N_SINK; k++) begin
      if (snk_xfer[k] && (rcv_q[k] != 32'hFFFF_FFFF)) begin
        rcv_d[k] = rcv_q[k] + 32'd1;
      end
    end

    // Windowed watchdog: no change in total progress over a full window
    if (active) begin
      win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
      if (win_q == '0) begin
        snap_d = progress;
      end
      trip = (win_q == WIN_LAST) && (progress == snap_q);
    end

    case (state_q)
      S_SEND: begin
        if (inj_xfer) begin
          if (last_pkt) begin
            addr_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (last_pkt && !loop_q) begin
            state_d = S_DRAIN;
          end else if (gap_q != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = 8'd0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == gap_q - 8'd1) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (|snk_xfer) begin
          idle_d = '0;
        end else if (idle_q == DC_LAST) begin
          state_d = S_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (start_ok) begin
      state_d   = S_SEND;
      addr_d    = '0;
      gap_cnt_d = 8'd0;
      idle_d    = '0;
      win_d     = '0;
      bp_d      = '0;
      sent_d    = '0;
      rcv_d     = '0;
    end

    // Deadlock outranks the drain timeout if both fire together
    if (trip) begin
      state_d = S_DEAD;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      gap_cnt_q <= 8'd0;
      idle_q    <= '0;
      win_q     <= '0;
      snap_q    <= '0;
      bp_q      <= '0;
      sent_q    <= '0;
      rcv_q     <= '0;
      pkt_num_q <= '0;
      loop_q    <= 1'b0;
      gap_q     <= 8'd0;
      bp_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      gap_cnt_q <= gap_cnt_d;
      idle_q    <= idle_d;
      win_q     <= win_d;
      snap_q    <= snap_d;
      bp_q      <= bp_d;
      sent_q    <= sent_d;
      rcv_q     <= rcv_d;
      if (start_ok) begin
        pkt_num_q <= pkt_num;
        loop_q    <= loop_en;
        gap_q     <= gap;
        bp_en_q   <= bp_en;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_harness.sv
module tb_noc_traffic_harness;
  localparam int DW = 32, DEPTH = 10000, NS = 2, WIN = 10000, DC = 1024, BP = 16;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rstn;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic start;
  logic [AW:0] pkt_num;
  logic loop_en;
  logic [7:0] gap;
  logic [NS-1:0] bp_en;
  logic [DW-1:0] data_o_stab;
  logic valid_o_stab;
  logic ready_i_stab;
  logic [NS*DW-1:0] data_i_flee;
  logic [NS-1:0] valid_i_flee;
  logic [NS-1:0] ready_o_flee;
  logic [31:0] sent_cnt;
  logic [NS*32-1:0] rcv_cnt;
  logic busy, done, deadlock;

  int vecs = 0;
  int errs = 0;
  logic [DW-1:0] tbm [64];

  noc_traffic_harness #(.DW(DW), .DEPTH(DEPTH), .N_SINK(NS), .WIN(WIN),
                        .DRAIN_CYC(DC), .BP_PERIOD(BP)) dut (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .pkt_num(pkt_num), .loop_en(loop_en), .gap(gap), .bp_en(bp_en),
    .data_o_stab(data_o_stab), .valid_o_stab(valid_o_stab), .ready_i_stab(ready_i_stab),
    .data_i_flee(data_i_flee), .valid_i_flee(valid_i_flee), .ready_o_flee(ready_o_flee),
    .sent_cnt(sent_cnt), .rcv_cnt(rcv_cnt), .busy(busy), .done(done), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic quiet_inputs();
    ld_en = 0; ld_addr = '0; ld_data = '0; start = 0; pkt_num = '0; loop_en = 0;
    gap = 8'd0; bp_en = '0; ready_i_stab = 0; data_i_flee = '0; valid_i_flee = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 0; quiet_inputs();
    @(negedge clk); rstn = 1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_en = 1; ld_addr = AW'(i); ld_data = $urandom; tbm[i] = ld_data;
    end
    @(negedge clk); ld_en = 0;
  endtask

  // Returns at the negedge of the first cycle after the accepting edge
  task automatic pulse_start(input int pn, input bit lp, input int g, input logic [NS-1:0] bp);
    @(negedge clk);
    start = 1; pkt_num = (AW+1)'(pn); loop_en = lp; gap = 8'(g); bp_en = bp;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin @(negedge clk); c++; end
    vecs++;
    if (done !== 1'b1) begin errs++; $display("FAIL %s: done=%b after %0d cycles, required 1", nm, done, c); end
  endtask

  task automatic test_reset();
    rstn = 0; quiet_inputs();
    #12;
    vecs++;
    if ({valid_o_stab, ready_o_flee, busy, done, deadlock} !== '0 || sent_cnt !== 0 || rcv_cnt !== '0) begin
      errs++;
      $display("FAIL reset_state: valid=%b rdy=%b busy=%b done=%b dl=%b sent=%0d rcv=%0h, required all 0",
               valid_o_stab, ready_o_flee, busy, done, deadlock, sent_cnt, rcv_cnt);
    end
    @(negedge clk); rstn = 1;
    @(negedge clk);
    vecs++;
    if (valid_o_stab !== 1'b0 || busy !== 1'b0 || ready_o_flee !== '0) begin
      errs++; $display("FAIL idle_after_reset: valid=%b busy=%b rdy=%b, required 0", valid_o_stab, busy, ready_o_flee);
    end
  endtask

  task automatic test_stream();
    int due_q[$];
    logic [DW-1:0] dat_q[$];
    int exp_i, last_rcv, done_c;
    bit ev;
    load(10);
    pulse_start(10, 0, 0, 2'b00);
    exp_i = 0; last_rcv = -1; done_c = -1;
    for (int c = 0; c < 3000 && done_c < 0; c++) begin
      ready_i_stab = 1;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        valid_i_flee = 2'b01; data_i_flee[DW-1:0] = dat_q[0];
      end else begin
        valid_i_flee = 2'b00;
      end
      ev = (c < 10);
      vecs++;
      if (valid_o_stab !== ev) begin errs++; $display("FAIL stream_valid c=%0d: got %b required %b", c, valid_o_stab, ev); end
      if (valid_o_stab === 1'b1) begin
        vecs++;
        if (data_o_stab !== tbm[exp_i % 64]) begin
          errs++; $display("FAIL stream_data #%0d: got %h required %h", exp_i, data_o_stab, tbm[exp_i % 64]);
        end
        due_q.push_back(c + 3); dat_q.push_back(data_o_stab); exp_i++;
      end
      if (valid_i_flee[0] && ready_o_flee[0]) begin
        void'(due_q.pop_front()); void'(dat_q.pop_front()); last_rcv = c;
      end
      if (done) done_c = c;
      @(negedge clk);
    end
    valid_i_flee = 2'b00;
    vecs++;
    if (done_c != last_rcv + 1 + DC) begin
      errs++; $display("FAIL drain_timing: done at cycle %0d, required %0d", done_c, last_rcv + 1 + DC);
    end
    vecs++;
    if (sent_cnt !== 32'd10 || rcv_cnt[31:0] !== 32'd10 || rcv_cnt[63:32] !== 32'd0) begin
      errs++; $display("FAIL stream_counts: sent=%0d rcv0=%0d rcv1=%0d, required 10 10 0",
                       sent_cnt, rcv_cnt[31:0], rcv_cnt[63:32]);
    end
  endtask

  task automatic test_gap();
    bit ev;
    pulse_start(4, 0, 3, 2'b00);
    for (int c = 0; c < 20; c++) begin
      ready_i_stab = 1;
      ev = (c < 16) && (c % 4 == 0);
      vecs++;
      if (valid_o_stab !== ev) begin errs++; $display("FAIL gap_valid c=%0d: got %b required %b", c, valid_o_stab, ev); end
      if (ev && data_o_stab !== tbm[c / 4]) begin
        errs++; $display("FAIL gap_data c=%0d: got %h required %h", c, data_o_stab, tbm[c / 4]);
      end
      @(negedge clk);
    end
    vecs++;
    if (sent_cnt !== 32'd4 || data_o_stab !== tbm[0]) begin
      errs++; $display("FAIL gap_end: sent=%0d data=%h, required 4 and %h", sent_cnt, data_o_stab, tbm[0]);
    end
    wait_done("gap_done", 2000);
  endtask

  task automatic test_loop_stall();
    int idx, ph;
    ph = $urandom_range(0, 1);
    pulse_start(3, 1, 0, 2'b00);
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      ready_i_stab = ((c + ph) % 2 == 1);
      vecs++;
      if (valid_o_stab !== 1'b1 || data_o_stab !== tbm[idx % 3] || done !== 1'b0) begin
        errs++; $display("FAIL loop c=%0d: valid=%b data=%h done=%b, required 1 %h 0",
                         c, valid_o_stab, data_o_stab, done, tbm[idx % 3]);
      end
      if (ready_i_stab) idx++;
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int n0, n1;
    logic [NS-1:0] er;
    pulse_start(1, 0, 0, 2'b10);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 160; c++) begin
      ready_i_stab = 1;
      valid_i_flee = 2'b11; data_i_flee = {$urandom, $urandom};
      er = {((c % BP) != BP - 1), 1'b1};
      vecs++;
      if (ready_o_flee !== er) begin errs++; $display("FAIL bp_ready c=%0d: got %b required %b", c, ready_o_flee, er); end
      n0 += er[0]; n1 += er[1];
      @(negedge clk);
    end
    valid_i_flee = 2'b00;
    @(negedge clk);
    vecs++;
    if (rcv_cnt[31:0] !== 32'(n0) || rcv_cnt[63:32] !== 32'(n1)) begin
      errs++; $display("FAIL bp_counts: rcv0=%0d rcv1=%0d, required %0d %0d", rcv_cnt[31:0], rcv_cnt[63:32], n0, n1);
    end
    wait_done("bp_done", 2000);
  endtask

  task automatic test_deadlock();
    int sent, dl_c;
    pulse_start(20, 0, 0, 2'b00);
    sent = 0; dl_c = -1;
    for (int c = 0; c < 2 * WIN + 100 && dl_c < 0; c++) begin
      ready_i_stab = (sent < 5);
      valid_i_flee = 2'b00;
      if (deadlock) dl_c = c;
      else if (valid_o_stab && ready_i_stab) sent++;
      @(negedge clk);
    end
    vecs++;
    if (dl_c != 2 * WIN) begin errs++; $display("FAIL deadlock_time: at cycle %0d, required %0d", dl_c, 2 * WIN); end
    vecs++;
    if (valid_o_stab !== 1'b0 || ready_o_flee !== 2'b00 || busy !== 1'b0 || sent_cnt !== 32'd5) begin
      errs++; $display("FAIL deadlock_outputs: valid=%b rdy=%b busy=%b sent=%0d, required 0 00 0 5",
                       valid_o_stab, ready_o_flee, busy, sent_cnt);
    end
    pulse_start(4, 0, 0, 2'b00);
    repeat (5) @(negedge clk);
    vecs++;
    if (deadlock !== 1'b1 || valid_o_stab !== 1'b0 || busy !== 1'b0 || sent_cnt !== 32'd5) begin
      errs++; $display("FAIL deadlock_sticky: dl=%b valid=%b busy=%b sent=%0d, required 1 0 0 5",
                       deadlock, valid_o_stab, busy, sent_cnt);
    end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    logic [DW-1:0] nv;
    pulse_start(10, 0, 0, 2'b00);
    for (int c = 0; c < 7; c++) begin
      ready_i_stab = 1;
      @(negedge clk);
    end
    vecs++;
    if (valid_o_stab !== 1'b1 || data_o_stab !== tbm[7]) begin
      errs++; $display("FAIL pre_reset: valid=%b data=%h, required 1 %h", valid_o_stab, data_o_stab, tbm[7]);
    end
    #2 rstn = 0;
    #1;
    vecs++;
    if ({valid_o_stab, ready_o_flee, busy, done, deadlock} !== '0 || sent_cnt !== 0 || rcv_cnt !== '0) begin
      errs++; $display("FAIL async_reset: valid=%b rdy=%b busy=%b sent=%0d, required all 0",
                       valid_o_stab, ready_o_flee, busy, sent_cnt);
    end
    quiet_inputs();
    @(negedge clk); rstn = 1;
    // Load and start in the same cycle: the run sees the new word
    @(negedge clk);
    nv = ~tbm[0]; tbm[0] = nv;
    ld_en = 1; ld_addr = '0; ld_data = nv;
    start = 1; pkt_num = (AW+1)'(10); loop_en = 0; gap = 8'd0; bp_en = 2'b00;
    @(negedge clk);
    start = 0; ld_en = 0;
    for (int c = 0; c < 10; c++) begin
      ready_i_stab = 1;
      ld_en = (c == 2); ld_addr = AW'(5); ld_data = ~tbm[5];
      vecs++;
      if (valid_o_stab !== 1'b1 || data_o_stab !== tbm[c]) begin
        errs++; $display("FAIL replay c=%0d: valid=%b data=%h, required 1 %h", c, valid_o_stab, data_o_stab, tbm[c]);
      end
      @(negedge clk);
    end
    ld_en = 0;
    vecs++;
    if (sent_cnt !== 32'd10 || valid_o_stab !== 1'b0) begin
      errs++; $display("FAIL replay_end: sent=%0d valid=%b, required 10 0", sent_cnt, valid_o_stab);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gap();
    test_loop_stall();
    test_backpressure();
    test_deadlock();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end
endmodule
